// File: rtl/painter_pkg.sv
// Shared definitions for the painter command engine: opcodes, command fields,
// default geometry and the FSM encoding.
package painter_pkg;

  localparam int unsigned WIDTH_DEF  = 640;
  localparam int unsigned HEIGHT_DEF = 480;
  localparam int unsigned CMD_W      = 32;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned CX_W       = 10;
  localparam int unsigned CY_W       = 9;
  localparam int unsigned COL_W      = 8;

  // Field positions within a command word
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 28;
  localparam int unsigned A_MSB  = 25;  // cx / rect width
  localparam int unsigned A_LSB  = 16;
  localparam int unsigned B_MSB  = 9;   // hline len; low bits carry cy, vlen, height, colour
  localparam int unsigned B_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
  localparam logic [OP_W-1:0] OP_SETCOL = 4'd1;
  localparam logic [OP_W-1:0] OP_MOVETO = 4'd2;
  localparam logic [OP_W-1:0] OP_HLINE  = 4'd3;
  localparam logic [OP_W-1:0] OP_VLINE  = 4'd4;
  localparam logic [OP_W-1:0] OP_RECT   = 4'd5;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [CX_W-1:0] a;
    logic [CX_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_DRAW = 2'd3
  } state_e;

endpackage

// File: rtl/painter_addr_gen.sv
// Rectangular pixel walker: registered x/y with row-major stepping, linear
// framebuffer address and off-screen clip flag.
module painter_addr_gen
  import painter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [CX_W-1:0]   x0,
  input  logic [CY_W-1:0]   y0,
  input  logic [CX_W-1:0]   cols,
  input  logic [CY_W-1:0]   rows,
  output logic [ADDR_W-1:0] addr,
  output logic              clip,
  output logic              last
);

  logic [CX_W-1:0] x, x_org, cols_q, col_left;
  logic [CY_W-1:0] y, row_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      x_org    <= '0;
      cols_q   <= '0;
      col_left <= '0;
      row_left <= '0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x_org    <= x0;
      cols_q   <= cols;
      col_left <= cols;
      row_left <= rows;
    end else if (step) begin
      if (col_left > CX_W'(1)) begin
        x        <= x + CX_W'(1);
        col_left <= col_left - CX_W'(1);
      end else begin
        // End of row: return to the left edge and drop one line
        x        <= x_org;
        y        <= y + CY_W'(1);
        col_left <= cols_q;
        row_left <= row_left - CY_W'(1);
      end
    end
  end

  assign addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  assign clip = (32'(x) >= WIDTH) || (32'(y) >= HEIGHT);
  assign last = (col_left == CX_W'(1)) && (row_left == CY_W'(1));

endmodule

// File: rtl/painter_engine.sv
// Command-queue drain stage: pops drawing commands and rasterises lines and
// rectangles into single-pixel framebuffer writes.
module painter_engine
  import painter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              q_empty,
  output logic              q_re,
  input  logic [CMD_W-1:0]  q_rd_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [COL_W-1:0]  fb_data,
  input  logic              fb_ready,
  output logic              busy,
  output logic              bad_op
);

  localparam int unsigned WC_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_e           state, state_nxt;
  cmd_t             cmd;
  logic             cmd_ld;
  logic [COL_W-1:0] colour, colour_nxt, draw_col, draw_col_nxt;
  logic [CX_W-1:0]  cx, cx_nxt;
  logic [CY_W-1:0]  cy, cy_nxt;
  logic             bad_nxt;
  logic [WC_W-1:0]  wait_cnt, wait_nxt;
  logic             ag_load, ag_step, ag_clip, ag_last;
  logic [CX_W-1:0]  ag_cols;
  logic [CY_W-1:0]  ag_rows;
  logic             unused_bits;

  // Reserved command bits carry no meaning
  assign unused_bits = ^{q_rd_data[27:26], q_rd_data[15:10]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd      <= '0;
      colour   <= '0;
      draw_col <= '0;
      cx       <= '0;
      cy       <= '0;
      bad_op   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      colour   <= colour_nxt;
      draw_col <= draw_col_nxt;
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      bad_op   <= bad_nxt;
      wait_cnt <= wait_nxt;
      if (cmd_ld) begin
        cmd <= '{op: q_rd_data[OP_MSB:OP_LSB],
                 a:  q_rd_data[A_MSB:A_LSB],
                 b:  q_rd_data[B_MSB:B_LSB]};
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    q_re         = 1'b0;
    fb_we        = 1'b0;
    cmd_ld       = 1'b0;
    wait_nxt     = wait_cnt;
    colour_nxt   = colour;
    draw_col_nxt = draw_col;
    cx_nxt       = cx;
    cy_nxt       = cy;
    bad_nxt      = bad_op;
    ag_load      = 1'b0;
    ag_step      = 1'b0;
    ag_cols      = cmd.b;
    ag_rows      = CY_W'(1);

    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          q_re      = 1'b1;
          wait_nxt  = WC_W'(1);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WC_W'(RD_LAT)) begin
          cmd_ld    = 1'b1;
          state_nxt = ST_EXEC;
        end else begin
          wait_nxt = wait_cnt + WC_W'(1);
        end
      end
      ST_EXEC: begin
        state_nxt = ST_IDLE;
        case (cmd.op)
          OP_NOP: begin
          end
          OP_SETCOL: colour_nxt = cmd.b[COL_W-1:0];
          OP_MOVETO: begin
            cx_nxt = cmd.a;
            cy_nxt = cmd.b[CY_W-1:0];
          end
          OP_HLINE: begin
            cx_nxt  = cx + cmd.b;
            ag_cols = cmd.b;
            ag_rows = CY_W'(1);
            ag_load = (cmd.b != '0);
          end
          OP_VLINE: begin
            cy_nxt  = cy + cmd.b[CY_W-1:0];
            ag_cols = CX_W'(1);
            ag_rows = cmd.b[CY_W-1:0];
            ag_load = (cmd.b[CY_W-1:0] != '0);
          end
          OP_RECT: begin
            ag_cols = cmd.a;
            ag_rows = cmd.b[CY_W-1:0];
            ag_load = (cmd.a != '0) && (cmd.b[CY_W-1:0] != '0);
          end
          default: bad_nxt = 1'b1;
        endcase
        // Colour is frozen for the whole draw at its start
        if (ag_load) begin
          draw_col_nxt = colour;
          state_nxt    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        fb_we = !ag_clip;
        if (ag_clip || fb_ready) begin
          ag_step = 1'b1;
          if (ag_last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  painter_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .reset(reset),
    .load (ag_load),
    .step (ag_step),
    .x0   (cx),
    .y0   (cy),
    .cols (ag_cols),
    .rows (ag_rows),
    .addr (fb_addr),
    .clip (ag_clip),
    .last (ag_last)
  );

  assign fb_data = draw_col;
  assign busy    = (state != ST_IDLE);

endmodule
